// File: rtl/accel_pkg.sv
// Shared types and constants for the accel_s2mm stream-to-memory writer.
package accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_FIN
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;

  // AXI awsize encoding for a bus of the given width
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/s2mm_burst_calc.sv
// Burst length selection: min(remaining, MAX_BURST, beats to next 4 KB page),
// registered as an AXI awlen value when load is asserted.
module s2mm_burst_calc
  import accel_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] addr_lo,
  input  logic [15:0] remaining,
  output logic [7:0]  awlen_q
);

  localparam int SIZE = $clog2(DATA_W / 8);

  logic [12:0] bytes_to_bound;
  logic [12:0] beats_to_bound;
  logic [16:0] len_c;
  logic [7:0]  awlen_d;

  always_comb begin
    bytes_to_bound = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
    beats_to_bound = bytes_to_bound >> SIZE;
    len_c = {1'b0, remaining};
    if ({4'b0, beats_to_bound} < len_c) len_c = {4'b0, beats_to_bound};
    if (17'(MAX_BURST) < len_c) len_c = 17'(MAX_BURST);
    awlen_d = load ? 8'(len_c - 17'd1) : awlen_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) awlen_q <= '0;
    else        awlen_q <= awlen_d;
  end

endmodule

// File: rtl/accel_s2mm.sv
// AXI-Stream to AXI4 memory-mapped writer: splits a job into 4 KB-safe INCR
// bursts, one outstanding at a time, padding out a burst cut short by s_tlast.
module accel_s2mm
  import accel_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         len_beats,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         beats_written,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  input  logic                s_tlast,
  output logic                s_tready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int SIZE = $clog2(DATA_W / 8);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         rem_q, rem_d;
  logic [15:0]         bw_q, bw_d;
  logic                error_q, error_d;
  logic                tlast_seen_q, tlast_seen_d;
  logic [8:0]          beat_cnt_q, beat_cnt_d;
  logic [8:0]          stream_cnt_q, stream_cnt_d;
  logic                zero_done_q, zero_done_d;
  logic                calc_load;
  logic                beat_fire;
  logic [8:0]          burst_len;

  s2mm_burst_calc #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) u_calc (
    .clk       (aclk),
    .rst_n     (aresetn),
    .load      (calc_load),
    .addr_lo   (addr_d[11:0]),
    .remaining (rem_d),
    .awlen_q   (awlen)
  );

  assign burst_len     = {1'b0, awlen} + 9'd1;
  assign awaddr        = addr_q;
  assign awsize        = axi_size(DATA_W);
  assign awburst       = BURST_INCR;
  assign busy          = (state_q != ST_IDLE);
  assign error         = error_q;
  assign beats_written = bw_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    bw_d         = bw_q;
    error_d      = error_q;
    tlast_seen_d = tlast_seen_q;
    beat_cnt_d   = beat_cnt_q;
    stream_cnt_d = stream_cnt_q;
    zero_done_d  = 1'b0;
    calc_load    = 1'b0;
    beat_fire    = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    wdata        = '0;
    wstrb        = '0;
    wlast        = 1'b0;
    s_tready     = 1'b0;
    bready       = 1'b0;
    done         = zero_done_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_beats != 16'd0) begin
            addr_d       = base_addr;
            rem_d        = len_beats;
            bw_d         = '0;
            error_d      = 1'b0;
            tlast_seen_d = 1'b0;
            calc_load    = 1'b1;
            state_d      = ST_ADDR;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end

      ST_ADDR: begin
        awvalid = 1'b1;
        if (awready) begin
          beat_cnt_d   = '0;
          stream_cnt_d = '0;
          state_d      = ST_DATA;
        end
      end

      ST_DATA: begin
        wlast = (beat_cnt_q == {1'b0, awlen});
        // After an early s_tlast the burst is finished with null-strobe beats
        if (tlast_seen_q) begin
          wvalid    = 1'b1;
          beat_fire = wready;
        end else begin
          wvalid    = s_tvalid;
          wdata     = s_tdata;
          wstrb     = '1;
          s_tready  = wready;
          beat_fire = s_tvalid && wready;
          if (beat_fire) begin
            stream_cnt_d = stream_cnt_q + 9'd1;
            if (s_tlast) tlast_seen_d = 1'b1;
          end
        end
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (wlast) state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          if (bresp != RESP_OKAY) error_d = 1'b1;
          bw_d   = bw_q + {7'b0, stream_cnt_q};
          addr_d = addr_q + (ADDR_W'(burst_len) << SIZE);
          rem_d  = rem_q - {7'b0, burst_len};
          if (rem_d == 16'd0 || tlast_seen_q) begin
            state_d = ST_FIN;
          end else begin
            calc_load = 1'b1;
            state_d   = ST_ADDR;
          end
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      bw_q         <= '0;
      error_q      <= 1'b0;
      tlast_seen_q <= 1'b0;
      beat_cnt_q   <= '0;
      stream_cnt_q <= '0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      bw_q         <= bw_d;
      error_q      <= error_d;
      tlast_seen_q <= tlast_seen_d;
      beat_cnt_q   <= beat_cnt_d;
      stream_cnt_q <= stream_cnt_d;
      zero_done_q  <= zero_done_d;
    end
  end

endmodule

// File: tb/tb_accel_s2mm.sv
// Directed bench for accel_s2mm: AXI slave / stream source model plus
// hand-computed burst, data and status expectations.
module tb_accel_s2mm;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       len_beats = '0;
  logic              busy, done, error;
  logic [15:0]       beats_written;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tlast = 1'b0;
  logic              s_tready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready = 1'b0;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast, wvalid;
  logic              wready = 1'b0;
  logic [1:0]        bresp = 2'b00;
  logic              bvalid = 1'b0;
  logic              bready;

  accel_s2mm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .len_beats(len_beats), .busy(busy), .done(done), .error(error),
    .beats_written(beats_written), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Model state
  logic [31:0] src_data [128];
  int          src_len = 0;
  int          src_idx = 0;
  int          tlast_at = -1;
  bit          rnd = 0;
  int          err_burst = -1;
  int          aw_cnt = 0;
  logic [31:0] aw_addr_log [32];
  logic [7:0]  aw_len_log [32];
  int          w_cnt = 0;
  logic [31:0] w_data_log [256];
  logic [3:0]  w_strb_log [256];
  logic        w_last_log [256];
  bit          outstanding = 0;
  int          aw_viol = 0;
  bit          b_pending = 0;
  int          b_delay = 0;
  int          b_idx = 0;
  int          done_cnt = 0;
  logic        err_at_done = 1'b0;

  task automatic model_clear(input logic [31:0] seed, input int slen);
    for (int i = 0; i < 128; i++) src_data[i] = seed + 32'(i * 32'h0101_0003);
    src_len = slen; src_idx = 0; aw_cnt = 0; w_cnt = 0; outstanding = 0;
    aw_viol = 0; b_pending = 0; b_delay = 0; b_idx = 0; done_cnt = 0;
    err_at_done = 1'b0; bvalid = 1'b0;
  endtask

  // Slave and source: drive on negedge, resolve handshakes 1 ns later
  always @(negedge aclk) begin
    awready  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    wready   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_tvalid = (src_idx < src_len) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
    s_tdata  = (src_idx < 128) ? src_data[src_idx] : 32'h0;
    s_tlast  = (src_idx == tlast_at);
    if (!b_pending) bvalid = 1'b0;
    else if (!bvalid) begin
      if (b_delay == 0) begin
        bvalid = 1'b1;
        bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      end else b_delay--;
    end
    #1;
    if (aresetn) begin
      if (done) begin
        done_cnt++;
        err_at_done = error;
      end
      if (awvalid && awready) begin
        if (outstanding) aw_viol++;
        outstanding = 1;
        if (aw_cnt < 32) begin
          aw_addr_log[aw_cnt] = awaddr;
          aw_len_log[aw_cnt]  = awlen;
        end
        aw_cnt++;
      end
      if (s_tvalid && s_tready) src_idx++;
      if (wvalid && wready) begin
        if (w_cnt < 256) begin
          w_data_log[w_cnt] = wdata;
          w_strb_log[w_cnt] = wstrb;
          w_last_log[w_cnt] = wlast;
        end
        w_cnt++;
        if (wlast) begin
          b_pending = 1;
          b_delay   = rnd ? $urandom_range(0, 3) : 0;
        end
      end
      if (bvalid && bready) begin
        b_pending   = 0;
        outstanding = 0;
        b_idx++;
      end
    end
  end

  task automatic start_job(input logic [31:0] base, input logic [15:0] len);
    @(negedge aclk);
    base_addr = base; len_beats = len; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge aclk);
      n++;
    end
    repeat (6) @(posedge aclk);
  endtask

  // Compare W log: first n_data beats carry stream data, rest are padding
  task automatic chk_wbeats(input string tag, input int n_data, input int n_total);
    int errs = 0;
    for (int i = 0; i < n_total && i < 256; i++) begin
      if (i < n_data) begin
        if (w_data_log[i] !== src_data[i] || w_strb_log[i] !== 4'hF) errs++;
      end else if (w_data_log[i] !== 32'h0 || w_strb_log[i] !== 4'h0) errs++;
    end
    chk({tag, "_wcnt"}, 64'(w_cnt), 64'(n_total));
    chk({tag, "_wbeats"}, 64'(errs), 64'd0);
  endtask

  initial begin
    int n;
    int lasts;
    model_clear(32'h0, 0);
    repeat (3) @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_awsize", awsize, 3'd2);
    chk("rst_awburst", awburst, 2'b01);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("idle_s_tready", s_tready, 0);
    chk("idle_bw", beats_written, 16'd0);

    // Three bursts across a page, always-ready slave
    model_clear(32'h1100_0000, 60);
    start_job(32'h1000, 16'd40);
    wait_done(2000);
    chk("j1_done", done_cnt, 1);
    chk("j1_awcnt", aw_cnt, 3);
    chk("j1_aw0", {aw_addr_log[0], 24'h0, aw_len_log[0]}, {32'h1000, 24'h0, 8'd15});
    chk("j1_aw1", {aw_addr_log[1], 24'h0, aw_len_log[1]}, {32'h1040, 24'h0, 8'd15});
    chk("j1_aw2", {aw_addr_log[2], 24'h0, aw_len_log[2]}, {32'h1080, 24'h0, 8'd7});
    chk("j1_bw", beats_written, 16'd40);
    chk("j1_err", error, 0);
    chk("j1_busy", busy, 0);
    chk_wbeats("j1", 40, 40);
    chk("j1_src", src_idx, 40);

    // 4 KB boundary split
    model_clear(32'h2200_0000, 8);
    start_job(32'h0FF8, 16'd8);
    wait_done(2000);
    chk("j2_awcnt", aw_cnt, 2);
    chk("j2_aw0", {aw_addr_log[0], 24'h0, aw_len_log[0]}, {32'h0FF8, 24'h0, 8'd1});
    chk("j2_aw1", {aw_addr_log[1], 24'h0, aw_len_log[1]}, {32'h1000, 24'h0, 8'd5});
    chk("j2_bw", beats_written, 16'd8);
    chk_wbeats("j2", 8, 8);

    // Early s_tlast on beat 5 of a 16-beat burst
    model_clear(32'h3300_0000, 20);
    tlast_at = 4;
    start_job(32'h5000, 16'd16);
    wait_done(2000);
    tlast_at = -1;
    chk("j3_done", done_cnt, 1);
    chk("j3_awcnt", aw_cnt, 1);
    chk("j3_awlen", aw_len_log[0], 8'd15);
    chk_wbeats("j3", 5, 16);
    lasts = 0;
    for (int i = 0; i < 16; i++) if (w_last_log[i]) lasts++;
    chk("j3_wlast_pos", {31'h0, w_last_log[15], 32'(lasts)}, {31'h0, 1'b1, 32'd1});
    chk("j3_bw", beats_written, 16'd5);
    chk("j3_src_stop", src_idx, 5);

    // SLVERR on the second of three bursts
    model_clear(32'h4400_0000, 40);
    err_burst = 1;
    start_job(32'h1000, 16'd40);
    wait_done(2000);
    err_burst = -1;
    chk("j4_awcnt", aw_cnt, 3);
    chk("j4_err_at_done", err_at_done, 1);
    chk("j4_err_sticky", error, 1);
    chk("j4_bw", beats_written, 16'd40);

    // Random backpressure, 100 beats; also error cleared by new start
    model_clear(32'h5500_0000, 110);
    rnd = 1;
    start_job(32'h2000, 16'd100);
    wait_done(20000);
    rnd = 0;
    chk("j5_done", done_cnt, 1);
    chk("j5_awcnt", aw_cnt, 7);
    chk("j5_aw6", {aw_addr_log[6], 24'h0, aw_len_log[6]}, {32'h2180, 24'h0, 8'd3});
    chk("j5_aw_viol", aw_viol, 0);
    chk("j5_err_clear", error, 0);
    chk("j5_bw", beats_written, 16'd100);
    chk_wbeats("j5", 100, 100);
    chk("j5_src_stop", src_idx, 100);

    // Zero-length start: done pulse, no traffic
    model_clear(32'h0, 10);
    start_job(32'h6000, 16'd0);
    wait_done(100);
    chk("j6_done", done_cnt, 1);
    chk("j6_awcnt", aw_cnt, 0);

    // Reset during DATA beat 3
    model_clear(32'h6600_0000, 40);
    start_job(32'h3000, 16'd16);
    n = 0;
    while (w_cnt < 2 && n < 200) begin
      @(posedge aclk);
      n++;
    end
    chk("j7_reached_beat3", w_cnt, 2);
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("j7_rst_hs", {awvalid, wvalid, wlast, bready, s_tready}, 5'b0);
    chk("j7_rst_status", {busy, done, error}, 3'b0);
    chk("j7_rst_regs", {16'h0, beats_written, 8'h0, awlen}, 64'h0);
    chk("j7_rst_awaddr", awaddr, 32'h0);
    chk("j7_rst_const", {awsize, awburst}, {3'd2, 2'b01});
    model_clear(32'h7700_0000, 8);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    start_job(32'h4000, 16'd8);
    wait_done(2000);
    chk("j8_done", done_cnt, 1);
    chk("j8_aw0", {aw_addr_log[0], 24'h0, aw_len_log[0]}, {32'h4000, 24'h0, 8'd7});
    chk("j8_bw", beats_written, 16'd8);
    chk_wbeats("j8", 8, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accel_s2mm.md
ACCEL_S2MM -- requirements
Module: accel_s2mm

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning AXI and AXIS data width in bits (power of two, 32..128).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning AXI address width.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning maximum AXI write burst length in beats (power of two, 1..256).
REQ-004 SHALL have port aclk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port aresetn, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have control ports: start in 1, base_addr in ADDR_W, len_beats in 16, busy out 1, done out 1 (one-cycle pulse), error out 1 (sticky), beats_written out 16.
REQ-007 SHALL have AXIS slave ports: s_tdata in DATA_W, s_tvalid in 1, s_tlast in 1, s_tready out 1.
REQ-008 SHALL have AXI write master ports: awaddr out ADDR_W, awlen out 8, awsize out 3, awburst out 2, awvalid out 1, awready in 1, wdata out DATA_W, wstrb out DATA_W/8, wlast out 1, wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1.

Function
REQ-009 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> (ADDR | FIN) -> IDLE.
REQ-010 SHALL, in IDLE with start=1 and len_beats!=0, latch base_addr and len_beats, clear error and beats_written, and enter ADDR next cycle; start with len_beats=0 SHALL pulse done without entering ADDR; start outside IDLE SHALL be ignored.
REQ-011 SHALL hold busy=1 in every state except IDLE.
REQ-012 SHALL compute burst length as min(remaining beats, MAX_BURST, beats to next 4 KB boundary), computed in ADDR; awlen = length-1.
REQ-013 SHALL drive awsize=log2(DATA_W/8), awburst=INCR, awvalid=1 in ADDR, and hold awaddr/awlen stable until awvalid&&awready, then enter DATA.
REQ-014 SHALL in DATA connect the stream combinationally: wdata=s_tdata, wvalid=s_tvalid, s_tready=wready, wstrb all ones, for each beat until the burst count is reached.
REQ-015 SHALL assert wlast on the final beat of each burst, counted independently of s_tlast.
REQ-016 SHALL, when s_tlast is accepted before the burst's final beat, deassert s_tready and complete the burst with padding beats: wvalid=1, wstrb=0, wdata=0; padding beats SHALL NOT count in beats_written.
REQ-017 SHALL in RESP hold bready=1; on bvalid, set error if bresp!=OKAY (2'b00), add the burst's stream beat count to beats_written, advance the address, and enter FIN if remaining==0 or s_tlast was seen, else ADDR.
REQ-018 SHALL not issue a new AW before the previous B is received (one outstanding burst).
REQ-019 SHALL pulse done for exactly one cycle in FIN, then return to IDLE; stream beats beyond len_beats SHALL remain unaccepted (s_tready=0).
REQ-020 SHALL keep s_tready=0 outside DATA and during padding.

Reset
REQ-021 SHALL, on aresetn low at any time including mid-burst, asynchronously force state IDLE and awvalid, wvalid, wlast, bready, s_tready, busy, done, error to 0, and beats_written, awaddr, awlen to 0.
REQ-022 SHALL leave awsize and awburst at their constant values throughout reset.

Structure
REQ-023 SHALL place the FSM state enum, the AXI burst/resp encodings (INCR, OKAY), and the 4 KB boundary constant in shared package accel_pkg.
REQ-024 SHALL use one sub-module, s2mm_burst_calc, computing burst length from address, remaining beats and MAX_BURST (combinational plus registered output).

Verification
REQ-025 SHALL cover: base 0x1000, len 40, MAX_BURST 16, always-ready slave -> bursts awlen 15,15,7 at 0x1000,0x1040,0x1080; done pulses once; beats_written=40.
REQ-026 SHALL cover: base 0x0FF8, len 8 -> bursts awlen 1 at 0x0FF8 and awlen 5 at 0x1000 (no 4 KB crossing).
REQ-027 SHALL cover: len 16, s_tlast on beat 5 -> 5 data beats with wstrb=all ones, 11 padding beats with wstrb=0, wlast on beat 16, beats_written=5.
REQ-028 SHALL cover: bresp=SLVERR on second of three bursts -> error=1 sticky through done, third burst still issued.
REQ-029 SHALL cover: random wready/s_tvalid/awready/bvalid backpressure, len 100 -> stream data order preserved at wdata, no AW while B outstanding.
REQ-030 SHALL cover: aresetn low during DATA beat 3 -> all outputs at reset values immediately; new start after release runs a clean job.
